// File: rtl/spi_master_arb.sv
// SPI master shared by NUM_REQ requesters through a round-robin arbiter.
// One full-duplex 8-bit transfer per grant, in the granted requester's cpol/cpha mode.
module spi_master_arb #(
    parameter int NUM_REQ  = 2,
    parameter int HALF_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] tx_data,
    input  logic [8*NUM_REQ-1:0] spcon_m,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rx_data,
    output logic                 busy,
    output logic                 sck,
    output logic                 ssn,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int HW = $clog2(HALF_DIV + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HALF_DIV - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, PRE, SETUP, XFER, HOLD, DONE} state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [4:0]    ecnt;
    logic [PW-1:0] ptr;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          cpol_l;
    logic          cpha_l;

    logic          half_tick;
    logic          win_vld;
    logic [PW-1:0] win_idx;
    int            c;

    assign half_tick = (hcnt == HLAST);

    // Search starts one past the last winner, so the last winner ranks lowest.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        c       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!win_vld && req[c]) begin
                win_vld = 1'b1;
                win_idx = PW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ssn     <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            rx_data <= '0;
            ptr     <= PW'(NUM_REQ - 1);
            hcnt    <= '0;
            ecnt    <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            cpol_l  <= 1'b0;
            cpha_l  <= 1'b0;
        end else begin
            done <= '0;
            hcnt <= (state == IDLE || half_tick) ? '0 : hcnt + 1'b1;
            case (state)
                IDLE: begin
                    ssn <= 1'b1;
                    if (win_vld) begin
                        gnt    <= ONE << win_idx;
                        ptr    <= win_idx;
                        tx_sh  <= tx_data[{win_idx, 3'b000} +: 8];
                        cpol_l <= spcon_m[{win_idx, 3'b010}];
                        cpha_l <= spcon_m[{win_idx, 3'b001}];
                        sck    <= spcon_m[{win_idx, 3'b010}];
                        ecnt   <= '0;
                        busy   <= 1'b1;
                        state  <= PRE;
                    end
                end
                PRE: begin
                    if (half_tick) begin
                        ssn   <= 1'b0;
                        state <= SETUP;
                        if (!cpha_l) begin
                            mosi  <= tx_sh[7];
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                    end
                end
                // The SETUP exit generates edge 1; XFER generates edges 2..16.
                SETUP, XFER: begin
                    if (half_tick) begin
                        sck  <= ~sck;
                        ecnt <= ecnt + 5'd1;
                        if (ecnt[0] == cpha_l) begin
                            rx_sh <= {rx_sh[6:0], miso};
                        end else if (cpha_l || ecnt != 5'd15) begin
                            mosi  <= tx_sh[7];
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                        state <= (ecnt == 5'd15) ? HOLD : XFER;
                    end
                end
                // ssn rises after H cycles; the following cycle hands off to DONE.
                HOLD: begin
                    if (ssn) begin
                        done    <= gnt;
                        rx_data <= rx_sh;
                        mosi    <= 1'b0;
                        state   <= DONE;
                    end else if (half_tick) begin
                        ssn <= 1'b1;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: loopback, slave-model modes, arbitration, reset abort, HALF_DIV=1.
module tb_spi_master_arb;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [1:0]  req, gnt, done;
    logic [15:0] tx_data, spcon_m;
    logic [7:0]  rx_data;
    logic        busy, sck, ssn, mosi, miso;

    logic [1:0]  req_b, gnt_b, done_b;
    logic [15:0] tx_b, spcon_b;
    logic [7:0]  rx_b;
    logic        busy_b, sck_b, ssn_b, mosi_b;

    logic [1:0]  mode_sel;
    logic        s_cpol, s_cpha, s_miso;
    logic [7:0]  s_tx, s_rx;
    int          s_idx;
    logic        ssn_q = 1'b1;
    logic        sck_q = 1'b0;
    logic        bad_gnt;

    int nvec  = 0;
    int nfail = 0;

    spi_master_arb #(.NUM_REQ(2), .HALF_DIV(2)) dut (
        .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .spcon_m(spcon_m),
        .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy),
        .sck(sck), .ssn(ssn), .mosi(mosi), .miso(miso)
    );

    spi_master_arb #(.NUM_REQ(2), .HALF_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req(req_b), .tx_data(tx_b), .spcon_m(spcon_b),
        .gnt(gnt_b), .done(done_b), .rx_data(rx_b), .busy(busy_b),
        .sck(sck_b), .ssn(ssn_b), .mosi(mosi_b), .miso(1'b0)
    );

    assign miso = (mode_sel == 2'd0) ? mosi : (mode_sel == 2'd1) ? s_miso : 1'b0;

    // Behavioural SPI slave: cpha=0 samples leading / shifts trailing, cpha=1 the reverse.
    always @(sck or ssn) begin
        if (ssn_q === 1'b1 && ssn === 1'b0) begin
            s_rx  = 8'h00;
            s_idx = 7;
            if (!s_cpha) begin
                s_miso = s_tx[7];
                s_idx  = 6;
            end
        end else if (sck !== sck_q && ssn === 1'b0 && !rst) begin
            if ((sck != s_cpol) ^ s_cpha) s_rx = {s_rx[6:0], mosi};
            else if (s_idx >= 0) begin
                s_miso = s_tx[s_idx];
                s_idx--;
            end
        end
        ssn_q = ssn;
        sck_q = sck;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the cycle index (1 = first tick) at which done is seen, or -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            tick(1);
            if ($countones(gnt) > 1 || $countones(done) > 1) bad_gnt = 1'b1;
            if (done != 2'b00) begin
                cyc = k;
                break;
            end
        end
        chk("wait_done_timeout", (cyc < 0), 1'b0);
    endtask

    initial begin
        int   cyc, edges, first, hi, low;
        logic prev;
        logic [7:0] spc;

        rst = 1'b1; req = '0; tx_data = '0; spcon_m = '0; mode_sel = 2'd0;
        req_b = '0; tx_b = '0; spcon_b = '0;
        s_cpol = 1'b0; s_cpha = 1'b0; s_tx = 8'h00; s_miso = 1'b0; s_rx = 8'h00; s_idx = 0;
        bad_gnt = 1'b0;
        tick(2);
        chk("reset_state", {sck, ssn, mosi, gnt, done, busy, rx_data}, {3'b010, 4'b0000, 1'b0, 8'h00});
        chk("reset_state_h1", {sck_b, ssn_b, mosi_b, gnt_b, done_b, busy_b, rx_b}, {3'b010, 4'b0000, 1'b0, 8'h00});
        rst = 1'b0;
        tick(1);

        // Mode 0 loopback, tx 0xA5
        req = 2'b01; tx_data = 16'h00A5; spcon_m = 16'h0000;
        edges = 0; first = -1; prev = sck;
        for (int n = 1; n <= 38; n++) begin
            tick(1);
            if (sck != prev) begin
                edges++;
                if (first < 0) first = n;
            end
            prev = sck;
            if (n == 1)  chk("m0_grant", {gnt, busy, ssn}, {2'b01, 1'b1, 1'b1});
            if (n == 2)  chk("m0_ssn_pre", ssn, 1'b1);
            if (n == 3)  chk("m0_ssn_low", {ssn, mosi}, 2'b01);
            if (n == 36) chk("m0_ssn_still_low", ssn, 1'b0);
            if (n == 37) chk("m0_ssn_high", {ssn, done}, {1'b1, 2'b00});
            if (n == 38) chk("m0_done", {done, rx_data, gnt}, {2'b01, 8'hA5, 2'b01});
        end
        chk("m0_edge_count", edges, 16);
        chk("m0_first_edge", first, 5);
        req = 2'b00;
        tick(1);
        chk("m0_after_done", {gnt, done, busy, mosi}, {2'b00, 2'b00, 1'b0, 1'b0});

        // Modes 1/2/3 against the slave model
        mode_sel = 2'd1;
        for (int i = 1; i < 4; i++) begin
            spc = 8'(i * 2);
            s_cpol = spc[2]; s_cpha = spc[1]; s_tx = 8'h3C;
            tx_data = 16'h00C3; spcon_m = {8'h00, spc}; req = 2'b01;
            tick(1);
            chk("mode_idle_sck", {sck, ssn}, {spc[2], 1'b1});
            wait_done(cyc);
            chk("mode_done_cycle", cyc, 37);
            chk("mode_master_rx", rx_data, 8'h3C);
            chk("mode_slave_rx", s_rx, 8'hC3);
            chk("mode_end_sck", sck, spc[2]);
            req = 2'b00;
            tick(2);
        end

        // Simultaneous requests from reset
        rst = 1'b1; tick(1); rst = 1'b0;
        mode_sel = 2'd0; spcon_m = 16'h0000; tx_data = 16'h2211; req = 2'b11;
        tick(1);
        chk("sim_first_gnt", gnt, 2'b01);
        wait_done(cyc);
        chk("sim_first_done", {done, rx_data}, {2'b01, 8'h11});
        req = 2'b10;
        tick(1);
        chk("sim_idle_gap", {gnt, ssn}, {2'b00, 1'b1});
        tick(1);
        chk("sim_second_gnt", gnt, 2'b10);
        wait_done(cyc);
        chk("sim_second_done", {done, rx_data}, {2'b10, 8'h22});

        // Both requesters held: grants alternate, ssn high between transfers
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_done(cyc);
            chk("alt_order", done, (t % 2) ? 2'b10 : 2'b01);
            chk("alt_rx", rx_data, (t % 2) ? 8'h22 : 8'h11);
            if (t < 3) begin
                hi = 0;
                for (int k = 0; k < 50; k++) begin
                    tick(1);
                    if ($countones(gnt) > 1) bad_gnt = 1'b1;
                    if (ssn) hi++;
                    else break;
                end
                chk("alt_ssn_gap", hi, 3);
            end
        end
        chk("no_double_grant", bad_gnt, 1'b0);
        req = 2'b00;
        tick(3);

        // Reset at edge 7
        tx_data = 16'h00A5; req = 2'b01;
        tick(17);
        chk("abort_pre_sck", {sck, ssn, gnt}, {1'b1, 1'b0, 2'b01});
        rst = 1'b1;
        #1;
        chk("abort_immediate", {sck, ssn, gnt, busy, done}, {1'b0, 1'b1, 2'b00, 1'b0, 2'b00});
        tick(2);
        chk("abort_no_done", {done, rx_data}, {2'b00, 8'h00});
        rst = 1'b0;
        wait_done(cyc);
        chk("abort_restart_cycle", cyc, 38);
        chk("abort_restart_rx", {done, rx_data}, {2'b01, 8'hA5});
        req = 2'b00;
        tick(2);

        // HALF_DIV=1, tx 0xFF, miso tied low
        req_b = 2'b01; tx_b = 16'h00FF; spcon_b = 16'h0000;
        low = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            if (!ssn_b) low++;
            if (n == 1)  chk("h1_grant", {gnt_b, ssn_b}, {2'b01, 1'b1});
            if (n == 2)  chk("h1_ssn_low", {ssn_b, mosi_b}, 2'b01);
            if (n == 19) chk("h1_ssn_high", {ssn_b, done_b}, {1'b1, 2'b00});
            if (n == 20) chk("h1_done", {done_b, rx_b}, {2'b01, 8'h00});
        end
        chk("h1_ssn_low_span", low, 17);
        req_b = 2'b00;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- SPI master engine with built-in round-robin arbiter.
- Shares one SPI bus (sck/ssn/mosi/miso) among NUM_REQ on-chip requesters.
- Each requester supplies an 8-bit tx byte and its own mode byte, in the same spcon layout the spi_slave uses (bit2 = cpol, bit1 = cpha).
- The block sequences one full-duplex 8-bit transfer per grant and returns the received byte with a done pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- HALF_DIV, 2, clk cycles per sck half-period (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request; level, held until matching done.
- tx_data  in  8*NUM_REQ  byte to send; requester i at [8i+7:8i].
- spcon_m  in  8*NUM_REQ  per-requester mode; bit2 cpol, bit1 cpha, other bits ignored.
- gnt  out  NUM_REQ  one-hot grant, high for the whole transfer.
- done  out  NUM_REQ  one-cycle pulse to the granted requester at end of transfer.
- rx_data  out  8  received byte, valid from the done pulse until the next done.
- busy  out  1  high in any state other than IDLE.
- sck  out  1  SPI clock.
- ssn  out  1  slave select, active low.
- mosi  out  1  master data out, MSB first.
- miso  in  1  slave data in.

Behaviour:
- Reset (async, rst=1): state IDLE, ssn=1, sck=0, mosi=0, gnt=0, done=0, busy=0, rx_data=0, RR pointer = NUM_REQ-1.
- Reset mid-transfer: outputs return to reset values immediately; no done is issued.
- Arbitration:
  - Evaluated only in IDLE.
  - Search starts at pointer+1 mod NUM_REQ; the first asserted req wins.
  - Pointer is updated to the winner.
  - req seen in IDLE at cycle 0 -> gnt one-hot at cycle 1.
  - The winner's tx_data and spcon_m are latched at grant; later changes are ignored until the next grant.
- States: IDLE -> PRE -> SETUP -> XFER -> HOLD -> DONE -> IDLE. H = HALF_DIV.
- IDLE: ssn=1; sck holds its last value.
- PRE (H cycles): sck <= latched cpol at entry; ssn stays 1, so any polarity change happens while deselected.
- SETUP (H cycles):
  - ssn <= 0 at entry (cycle 1+H).
  - If cpha=0, mosi <= tx[7] at the same cycle.
- XFER:
  - 16 sck edges, one every H cycles; first edge at cycle 1+2H.
  - Edges are numbered 1..16; odd = leading, even = trailing.
  - cpha=0: sample miso on odd edges; shift mosi on even edges 2..14.
  - cpha=1: shift mosi on odd edges (edge 1 drives tx[7]); sample miso on even edges.
  - Sampling captures miso in the clk cycle that generates the edge; shift-in is MSB first.
  - After edge 16, sck equals cpol.
- HOLD (H cycles after edge 16): mosi unchanged; ssn <= 1 at exit (cycle 1+18H).
- DONE (1 cycle, cycle 2+18H):
  - done[g]=1 and rx_data updated in the same cycle.
  - gnt drops at the exit of DONE.
  - mosi <= 0.
- IDLE is held at least one cycle between transfers, so ssn is high >= 2 cycles.
- A requester still holding req after done re-enters arbitration at the lowest RR priority.
- req dropped while granted: the transfer completes normally and done still pulses. Abort only via rst.
- Counters:
  - Half-period counter is ceil(log2(HALF_DIV+1)) bits and wraps to 0 at H-1.
  - Edge counter is 5 bits, 0..16.
- Only one gnt bit is ever high; gnt, done and busy are registered.

Test Plan:
- Mode 0 loopback (miso=mosi), H=2, req0 with tx 0xA5, spcon 0x00 -> ssn low at cycle 3, 16 sck edges from cycle 5, ssn high at cycle 37, done[0] at cycle 38, rx_data=0xA5.
- Modes 1/2/3 (spcon 0x02, 0x04, 0x06) against an spi_slave with matching spcon_s and data_s=0x3C, master tx 0xC3:
  - master rx_data=0x3C; slave data_r_s=0xC3.
  - Idle sck = cpol, set before ssn falls.
- Simultaneous req0=req1=1 from reset, tx 0x11/0x22 -> gnt0 first, then gnt1; rx order 0x11, 0x22 in loopback.
- Both requesters holding req continuously -> grants alternate 0,1,0,1; no double grant; ssn high >= 2 cycles between transfers.
- rst pulsed at edge 7 of a transfer -> sck=0, ssn=1, gnt=0 immediately, no done. A fresh req0 afterwards completes normally.
- HALF_DIV=1, tx 0xFF, miso tied 0 -> ssn low-to-high spans 17 cycles (cycles 2..19), rx_data=0x00, done at cycle 20.
